// File: rtl/calc_prog_issuer.sv
// calc_prog_issuer: buffers host instructions, streams them into the calculator's load mode and drives execute runs.
// Optional feature macro: OVF_ABORT_EN ends an execute run on the first sampled overflow.
module calc_prog_issuer #(
  parameter int CACHE_DEPTH = 32,
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opcode,
  input  logic [3:0] in_value,
  input  logic       run,
  input  logic [7:0] run_steps,
  input  logic       clear,
  input  logic       cache_full,
  input  logic       overflow,
  output logic       mode,
  output logic [2:0] op_code,
  output logic [3:0] value,
  output logic       calc_rst,
  output logic       busy,
  output logic       done,
  output logic [5:0] loaded_count,
  output logic [7:0] rejected_count,
  output logic [7:0] ovf_count
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] QD = (AW+1)'(QDEPTH);
  localparam logic [5:0] CD = 6'(CACHE_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, FIN} state_t;
  state_t state, state_nx;
  logic [6:0] fifo [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic run_pending, sample, reject, push, pop, can_load, clear_ok, stop, ovf_hit;
  logic [7:0] steps, step_cnt;
  assign in_ready = count != QD;
  assign busy = state != IDLE;
  assign reject = in_opcode[1:0] == 2'b11;
  assign push = in_valid && in_ready && !reject;
  assign pop = state_nx == LOAD;
  assign can_load = count != '0 && loaded_count < CD && !cache_full;
  assign clear_ok = clear && state == IDLE;
`ifdef OVF_ABORT_EN
  assign stop = step_cnt == 8'd0 || (sample && overflow);
  assign ovf_hit = sample && overflow && ovf_count == 8'd0;
`else
  assign stop = step_cnt == 8'd0;
  assign ovf_hit = sample && overflow;
`endif
  // next state: clear holds IDLE for its reset pulse, loading takes priority over a pending run
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = clear_ok ? IDLE : can_load ? LOAD : !run_pending ? IDLE :
                       (steps == 8'd0 || loaded_count == 6'd0) ? FIN : EXEC;
      LOAD: state_nx = can_load ? LOAD : IDLE;
      EXEC: state_nx = stop ? FIN : EXEC;
      default: state_nx = IDLE;
    endcase
  end
  // instruction storage; pointers and occupancy live in the reset domain below
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= {in_opcode, in_value};
  end
  // registered control and calculator-facing outputs, driven from the upcoming state so they align with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      run_pending <= 1'b0;
      steps <= 8'd0;
      step_cnt <= 8'd0;
      sample <= 1'b0;
      mode <= 1'b0;
      op_code <= 3'b111;
      value <= 4'd0;
      calc_rst <= 1'b1;
      done <= 1'b0;
      loaded_count <= 6'd0;
      rejected_count <= 8'd0;
      ovf_count <= 8'd0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + (AW)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW)'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      run_pending <= run || (run_pending && !(state == IDLE && state_nx inside {EXEC, FIN}));
      if (run) steps <= run_steps;
      step_cnt <= state_nx != EXEC ? 8'd0 : state == EXEC ? step_cnt - 8'd1 : steps - 8'd1;
      sample <= mode;
      mode <= state_nx == EXEC;
      op_code <= pop ? fifo[rd_ptr][6:4] : state_nx == EXEC ? 3'b000 : 3'b111;
      value <= pop ? fifo[rd_ptr][3:0] : 4'd0;
      calc_rst <= clear_ok;
      done <= state_nx == FIN;
      loaded_count <= clear_ok ? 6'd0 : loaded_count + 6'(pop);
      if (in_valid && in_ready && reject && rejected_count != 8'hff) rejected_count <= rejected_count + 8'd1;
      ovf_count <= run ? 8'd0 : (ovf_hit && ovf_count != 8'hff) ? ovf_count + 8'd1 : ovf_count;
    end
  end
endmodule
